// File: rtl/pc_return_stack.sv
// Return-address stack paired with the program counter: a bounded LIFO of
// registered entries with full/empty status and one-cycle overflow/underflow pulses.
module pc_return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_addr,
  output logic [WIDTH-1:0] top_addr,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] r_entry [DEPTH];
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic [AW-1:0]    w_ptr;
  logic [AW-1:0]    w_top_idx;
  logic             w_empty;
  logic             w_full;

  // Next free slot is the low bits of count; the top is one below it (mod DEPTH).
  assign w_ptr     = r_count[AW-1:0];
  assign w_top_idx = w_ptr - AW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);

  assign top_addr  = w_empty ? '0 : r_entry[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      case ({push, pop})
        2'b10: begin
          // A full stack rejects the call rather than dropping the oldest entry.
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_entry[w_ptr] <= push_addr;
            r_count        <= r_count + ONE_CNT;
          end
        end
        2'b01: begin
          if (w_empty) r_underflow <= 1'b1;
          else         r_count     <= r_count - ONE_CNT;
        end
        2'b11: begin
          // Return-then-call replaces the top; on an empty stack the call still lands.
          if (w_empty) begin
            r_entry[0]  <= push_addr;
            r_count     <= ONE_CNT;
            r_underflow <= 1'b1;
          end else begin
            r_entry[w_top_idx] <= push_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Bench for pc_return_stack: directed vector table, a reset-while-full sequence,
// and a randomized run against a small LIFO model.
module tb_pc_return_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int EW    = WIDTH + AW + 1 + 4;

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_addr;
  logic [WIDTH-1:0] top_addr;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  pc_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             psh;
    logic             pp;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] top;
    logic [AW:0]      cnt;
    logic             emp;
    logic             ful;
    logic             ovf;
    logic             unf;
  } vec_t;

  vec_t           vecs[$];
  logic [EW-1:0]  exp_q[$];
  int             tests_run = 0;
  int             tests_failed = 0;
  int             step_no = 0;

  // model state for the random section
  logic [WIDTH-1:0] m_ent [DEPTH];
  int               m_cnt;

  task automatic add_vec(input logic rst, input logic psh, input logic pp,
                         input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] top,
                         input int cnt, input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.psh = psh; v.pp = pp; v.addr = addr; v.top = top;
    v.cnt = (AW+1)'(cnt);
    v.emp = (cnt == 0);
    v.ful = (cnt == DEPTH);
    v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", step_no, name, act, exp);
    end
  endtask

  // scoreboard: compare DUT outputs with the oldest queued expectation
  task automatic compare_out();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL step %0d scoreboard: expectation queue empty", step_no);
      return;
    end
    e = exp_q.pop_front();
    check("top_addr",  32'(top_addr),  32'(e[EW-1 -: WIDTH]));
    check("count",     32'(count),     32'(e[4 +: AW+1]));
    check("empty",     32'(empty),     32'(e[3]));
    check("full",      32'(full),      32'(e[2]));
    check("overflow",  32'(overflow),  32'(e[1]));
    check("underflow", 32'(underflow), 32'(e[0]));
  endtask

  // driver: apply one cycle of inputs, queue its expectation, sample after the edge
  task automatic drive(input logic rst, input logic psh, input logic pp,
                       input logic [WIDTH-1:0] addr, input logic [EW-1:0] e);
    reset = rst; push = psh; pop = pp; push_addr = addr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    compare_out();
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic [WIDTH-1:0] top, input int cnt,
                                             input logic ovf, input logic unf);
    return {top, (AW+1)'(cnt), logic'(cnt == 0), logic'(cnt == DEPTH), ovf, unf};
  endfunction

  task automatic model_step(input logic rst, input logic psh, input logic pp,
                            input logic [WIDTH-1:0] addr);
    logic ovf, unf;
    logic [WIDTH-1:0] top;
    ovf = 1'b0; unf = 1'b0;
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
    end else if (psh && !pp) begin
      if (m_cnt == DEPTH) ovf = 1'b1;
      else begin m_ent[m_cnt] = addr; m_cnt++; end
    end else if (!psh && pp) begin
      if (m_cnt == 0) unf = 1'b1;
      else m_cnt--;
    end else if (psh && pp) begin
      if (m_cnt == 0) begin m_ent[0] = addr; m_cnt = 1; unf = 1'b1; end
      else m_ent[m_cnt-1] = addr;
    end
    top = (m_cnt == 0) ? '0 : m_ent[m_cnt-1];
    drive(rst, psh, pp, addr, pack_exp(top, m_cnt, ovf, unf));
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0;

    // rst psh pop addr   | top     cnt ovf unf
    add_vec(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec(0, 1, 0, 16'h0011, 16'h0011, 1, 0, 0);
    add_vec(0, 1, 0, 16'h0022, 16'h0022, 2, 0, 0);
    add_vec(0, 1, 0, 16'h0033, 16'h0033, 3, 0, 0);
    add_vec(0, 1, 0, 16'h0044, 16'h0044, 4, 0, 0);
    add_vec(0, 1, 0, 16'h0055, 16'h0044, 4, 1, 0);
    add_vec(0, 0, 0, 16'h0000, 16'h0044, 4, 0, 0);
    add_vec(0, 0, 1, 16'h0000, 16'h0033, 3, 0, 0);
    add_vec(0, 0, 1, 16'h0000, 16'h0022, 2, 0, 0);
    add_vec(0, 0, 1, 16'h0000, 16'h0011, 1, 0, 0);
    add_vec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1);
    add_vec(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec(0, 1, 1, 16'h0077, 16'h0077, 1, 0, 1);
    add_vec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec(0, 1, 0, 16'h0011, 16'h0011, 1, 0, 0);
    add_vec(0, 1, 0, 16'h0022, 16'h0022, 2, 0, 0);
    add_vec(0, 1, 1, 16'h00AA, 16'h00AA, 2, 0, 0);
    add_vec(0, 0, 1, 16'h0000, 16'h0011, 1, 0, 0);
    add_vec(0, 1, 0, 16'h0033, 16'h0033, 2, 0, 0);
    add_vec(0, 1, 0, 16'h0044, 16'h0044, 3, 0, 0);
    add_vec(0, 1, 0, 16'h0055, 16'h0055, 4, 0, 0);
    add_vec(0, 1, 1, 16'h0066, 16'h0066, 4, 0, 0);
    add_vec(0, 0, 1, 16'h0000, 16'h0044, 3, 0, 0);
    add_vec(1, 1, 0, 16'h0099, 16'h0000, 0, 0, 0);
    add_vec(0, 1, 0, 16'h0012, 16'h0012, 1, 0, 0);
    add_vec(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);

    foreach (vecs[i])
      drive(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].addr,
            {vecs[i].top, vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf});

    // reset while full, with an overflowing push pending, then flags must stay low
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
    for (int i = 0; i < DEPTH; i++) model_step(1'b0, 1'b1, 1'b0, WIDTH'(16'h0100 + i));
    model_step(1'b0, 1'b1, 1'b0, 16'hBEEF);
    model_step(1'b1, 1'b1, 1'b0, 16'hDEAD);
    model_step(1'b0, 1'b0, 1'b0, 16'h0000);
    model_step(1'b0, 1'b1, 1'b1, 16'h0321);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++)
      model_step(logic'($urandom_range(0, 40) == 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 16'hFFFF)));

    if (exp_q.size() != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL scoreboard drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
